circle_arc_engine: RTL and testbench
====================================

# circle_arc_engine

Parametrised successor to the fixed-size circle drawer. It rasterises a Bresenham midpoint circle of any radius and screen size, and emits one candidate pixel per clock on the VGA plot interface. New behaviour: a per-octant enable mask for drawing arcs, and hardware clipping, so off-screen pixels are suppressed instead of wrapping. It sits between the drawing controller and the VGA adapter's plot port.

## Interface
- `X_W`, default 8: width of x coordinates.
- `Y_W`, default 7: width of y coordinates.
- `R_W`, default 8: width of the radius.
- `SCREEN_W`, default 160: number of visible columns; x must be < `SCREEN_W`.
- `SCREEN_H`, default 120: number of visible rows; y must be < `SCREEN_H`.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `colour`  in  3  pixel colour, latched at start.
- `centre_x`  in  `X_W`  circle centre x, latched at start.
- `centre_y`  in  `Y_W`  circle centre y, latched at start.
- `radius`  in  `R_W`  circle radius, latched at start.
- `octant_mask`  in  8  bit k-1 enables octant k; latched at start.
- `start`  in  1  level request; held high until `done` is seen.
- `done`  out  1  drawing complete.
- `vga_x`  out  `X_W`  pixel x.
- `vga_y`  out  `Y_W`  pixel y.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  write strobe for the current pixel.

## Operation
- States:
  - IDLE: waits for `start`=1, then goes to INIT.
  - INIT: latches all inputs; sets ox=radius, oy=0, crit=1-radius.
  - PLOT1..PLOT8: one cycle each.
  - DONE: holds until `start`=0, then returns to IDLE.
- Octant coordinates in PLOTk, computed signed at `X_W`+2 / `Y_W`+2 bits (cx, cy are the latched centre):
  - 1: (cx+ox, cy+oy)
  - 2: (cx+oy, cy+ox)
  - 3: (cx-oy, cy+ox)
  - 4: (cx-ox, cy+oy)
  - 5: (cx-ox, cy-oy)
  - 6: (cx-oy, cy-ox)
  - 7: (cx+oy, cy-ox)
  - 8: (cx+ox, cy-oy)
- Plot rule: `vga_plot`=1 only when the mask bit for octant k is set AND 0<=x<`SCREEN_W` AND 0<=y<`SCREEN_H`. Masked and clipped octants still consume their cycle.
- `vga_x`/`vga_y` carry the low `X_W`/`Y_W` bits of the coordinate in every PLOT state. Outside PLOT they are 0.
- Update on the PLOT8 exit edge:
  - Always: oy+=1.
  - If crit<=0: crit+=2*oy_new+1.
  - Else: ox-=1, then crit+=2*(oy_new-ox_new)+1.
  - If oy_new>ox_new go to DONE, else go to PLOT1.
- crit is signed, `R_W`+3 bits, and must not overflow for radius=2^`R_W`-1.
- Duplicate pixels (on the axes and diagonals, radius 0) are plotted again, not deduplicated.
- `start` falling during drawing is ignored. On reaching DONE with `start`=0, `done` is high for exactly one cycle, then IDLE.
- Input changes after INIT have no effect until the next start.

## Timing
- All outputs derive from registered state; there is no combinational input-to-output path.
- Reset: while `rst_n`=0 at a rising edge, go to IDLE. Registered values: `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0. Applies mid-draw; there is no resumption.
- Latency: with `start` sampled high at edge E0:
  - INIT occupies the cycle after E0.
  - PLOT1 of step 0 follows E1.
  - For N Bresenham steps, DONE follows edge E(8N+1).
- Radius 3 gives N=3, so `done` follows E25. Radius 0 gives N=1, so `done` follows E9.
- `done` falls one edge after `start` is sampled low. A new start needs at least one IDLE cycle.

## Test plan
- Centre (80,60), r=3, mask FF:
  - 24 PLOT cycles; first pixel (83,60) with `vga_plot`=1.
  - Step-1 octant 1 pixel is (83,61); step-2 octant 1 pixel is (82,62).
  - `done`=1 after E25. Drop `start` and `done`=0 one cycle later.
- Same circle, mask 8'h01: exactly 3 plots, at (83,60), (83,61), (82,62). `done` timing is unchanged.
- Centre (0,0), r=3, mask FF: step 0 plots octants 1, 2, 3, 8 only, at (3,0), (0,3), (0,3), (3,0). No x/y wrap is ever strobed.
- Centre (159,119), r=2, defaults: no pixel with x>=160 or y>=120 is strobed. (158,119) is suppressed only by its mask bit, never by clipping.
- Radius 0 at (10,10): 8 strobes at (10,10); `done` after E9.
- Assert `rst_n`=0 at E10 of an r=3 draw: all outputs are 0 the next cycle. A fresh start then redraws from PLOT1 step 0.

Source files
------------

// File: rtl/circle_arc_engine.sv
`default_nettype none
// ============================================================================
// circle_arc_engine : midpoint-circle rasteriser with octant mask and clipping
// Rev 1.0
// ============================================================================
module circle_arc_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     colour,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  input  logic [7:0]     octant_mask,
  input  logic           start,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  localparam int MAXW = (X_W > Y_W) ? ((X_W > R_W) ? X_W : R_W)
                                    : ((Y_W > R_W) ? Y_W : R_W);
  // Coordinate width leaves headroom so clipping sees true signed values.
  localparam int CW = MAXW + 3;
  localparam int OW = R_W + 2;
  localparam int KW = R_W + 3;

  localparam logic signed [OW-1:0] C_O_ONE = OW'(1);
  localparam logic signed [KW-1:0] C_K_ONE = KW'(1);
  localparam logic signed [CW-1:0] C_SW    = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] C_SH    = CW'(SCREEN_H);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_INIT = 4'd1,
    S_P1 = 4'd2, S_P2 = 4'd3, S_P3 = 4'd4, S_P4 = 4'd5,
    S_P5 = 4'd6, S_P6 = 4'd7, S_P7 = 4'd8, S_P8 = 4'd9,
    S_DONE = 4'd10
  } state_t;

  state_t                r_state, w_state_nx;
  logic [2:0]            r_col;
  logic [X_W-1:0]        r_cx;
  logic [Y_W-1:0]        r_cy;
  logic [7:0]            r_mask;
  logic signed [OW-1:0]  r_ox, r_oy;
  logic signed [KW-1:0]  r_crit;

  logic                  w_crit_le0, w_step_done;
  logic signed [OW-1:0]  w_ox_nx, w_oy_nx;
  logic signed [KW-1:0]  w_ox_k, w_oy_k, w_crit_nx;

  assign w_crit_le0  = r_crit[KW-1] || (r_crit == '0);
  assign w_oy_nx     = r_oy + C_O_ONE;
  assign w_ox_nx     = w_crit_le0 ? r_ox : (r_ox - C_O_ONE);
  assign w_oy_k      = {w_oy_nx[OW-1], w_oy_nx};
  assign w_ox_k      = {w_ox_nx[OW-1], w_ox_nx};
  assign w_crit_nx   = w_crit_le0 ? (r_crit + (w_oy_k <<< 1) + C_K_ONE)
                                  : (r_crit + ((w_oy_k - w_ox_k) <<< 1) + C_K_ONE);
  assign w_step_done = (w_oy_nx > w_ox_nx);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nx = S_INIT;
      S_INIT:  w_state_nx = S_P1;
      S_P1:    w_state_nx = S_P2;
      S_P2:    w_state_nx = S_P3;
      S_P3:    w_state_nx = S_P4;
      S_P4:    w_state_nx = S_P5;
      S_P5:    w_state_nx = S_P6;
      S_P6:    w_state_nx = S_P7;
      S_P7:    w_state_nx = S_P8;
      S_P8:    w_state_nx = w_step_done ? S_DONE : S_P1;
      S_DONE:  if (!start) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_mask  <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_crit  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_INIT) begin
        r_col  <= colour;
        r_cx   <= centre_x;
        r_cy   <= centre_y;
        r_mask <= octant_mask;
        r_ox   <= {2'b00, radius};
        r_oy   <= '0;
        r_crit <= C_K_ONE - $signed({3'b000, radius});
      end
      if (r_state == S_P8) begin
        r_ox   <= w_ox_nx;
        r_oy   <= w_oy_nx;
        r_crit <= w_crit_nx;
      end
    end
  end

  logic signed [CW-1:0] w_cx_s, w_cy_s, w_ox_s, w_oy_s, w_px, w_py;
  logic [2:0]           w_oct;
  logic                 w_in_plot, w_on_screen;

  assign w_cx_s = {{(CW-X_W){1'b0}}, r_cx};
  assign w_cy_s = {{(CW-Y_W){1'b0}}, r_cy};
  assign w_ox_s = {{(CW-OW){r_ox[OW-1]}}, r_ox};
  assign w_oy_s = {{(CW-OW){r_oy[OW-1]}}, r_oy};

  always_comb begin
    w_px      = '0;
    w_py      = '0;
    w_oct     = 3'd0;
    w_in_plot = 1'b0;
    unique case (r_state)
      S_P1: begin w_in_plot = 1'b1; w_oct = 3'd0; w_px = w_cx_s + w_ox_s; w_py = w_cy_s + w_oy_s; end
      S_P2: begin w_in_plot = 1'b1; w_oct = 3'd1; w_px = w_cx_s + w_oy_s; w_py = w_cy_s + w_ox_s; end
      S_P3: begin w_in_plot = 1'b1; w_oct = 3'd2; w_px = w_cx_s - w_oy_s; w_py = w_cy_s + w_ox_s; end
      S_P4: begin w_in_plot = 1'b1; w_oct = 3'd3; w_px = w_cx_s - w_ox_s; w_py = w_cy_s + w_oy_s; end
      S_P5: begin w_in_plot = 1'b1; w_oct = 3'd4; w_px = w_cx_s - w_ox_s; w_py = w_cy_s - w_oy_s; end
      S_P6: begin w_in_plot = 1'b1; w_oct = 3'd5; w_px = w_cx_s - w_oy_s; w_py = w_cy_s - w_ox_s; end
      S_P7: begin w_in_plot = 1'b1; w_oct = 3'd6; w_px = w_cx_s + w_oy_s; w_py = w_cy_s - w_ox_s; end
      S_P8: begin w_in_plot = 1'b1; w_oct = 3'd7; w_px = w_cx_s + w_ox_s; w_py = w_cy_s - w_oy_s; end
      default: ;
    endcase
  end

  assign w_on_screen = !w_px[CW-1] && (w_px < C_SW) && !w_py[CW-1] && (w_py < C_SH);

  assign vga_plot   = w_in_plot && r_mask[w_oct] && w_on_screen;
  assign vga_x      = w_px[X_W-1:0];
  assign vga_y      = w_py[Y_W-1:0];
  assign vga_colour = w_in_plot ? r_col : 3'd0;
  assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_circle_arc_engine.sv
`default_nettype none
// ============================================================================
// tb_circle_arc_engine : directed self-checking bench for circle_arc_engine
// Rev 1.0
// ============================================================================
module tb_circle_arc_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic [7:0] octant_mask;
  logic       start;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  circle_arc_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .colour      (colour),
    .centre_x    (centre_x),
    .centre_y    (centre_y),
    .radius      (radius),
    .octant_mask (octant_mask),
    .start       (start),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int px [64];
  int py [64];
  int pl [64];
  int pc [64];
  int qx [$];
  int qy [$];
  int done_edge;
  int n_plots;
  int n_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a draw and records every PLOT cycle until done or the bound expires.
  task automatic run_draw(input int cx, input int cy, input int r, input int m, input int col);
    centre_x    = cx[7:0];
    centre_y    = cy[6:0];
    radius      = r[7:0];
    octant_mask = m[7:0];
    colour      = col[2:0];
    start       = 1'b1;
    qx.delete();
    qy.delete();
    n_plots   = 0;
    n_bad     = 0;
    done_edge = -1;
    for (int i = 0; i < 64; i++) begin px[i] = -1; py[i] = -1; pl[i] = -1; pc[i] = -1; end
    tick();
    for (int e = 1; e <= 300; e++) begin
      tick();
      if (e == 1) begin
        centre_x = 8'd7; centre_y = 7'd7; radius = 8'd50; octant_mask = 8'h00; colour = 3'd0;
      end
      if (e - 1 < 64) begin
        px[e-1] = int'(vga_x); py[e-1] = int'(vga_y); pl[e-1] = int'(vga_plot); pc[e-1] = int'(vga_colour);
      end
      if (vga_plot) begin
        n_plots++;
        qx.push_back(int'(vga_x));
        qy.push_back(int'(vga_y));
        if (vga_x >= 8'd160 || vga_y >= 7'd120) n_bad++;
      end
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic finish_draw();
    start = 1'b0;
    tick();
  endtask

  int pat;

  initial begin
    rst_n = 1'b0; start = 1'b0; colour = 3'd0; centre_x = '0; centre_y = '0;
    radius = '0; octant_mask = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_done",   int'(done), 0);
    chk("rst_plot",   int'(vga_plot), 0);
    chk("rst_x",      int'(vga_x), 0);
    chk("rst_y",      int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);

    // Full circle, r=3 at (80,60)
    run_draw(80, 60, 3, 8'hFF, 5);
    chk("c1_done_edge", done_edge, 25);
    chk("c1_nplots",    n_plots, 24);
    chk("c1_p0_x",      px[0], 83);
    chk("c1_p0_y",      py[0], 60);
    chk("c1_p0_plot",   pl[0], 1);
    chk("c1_p0_colour", pc[0], 5);
    chk("c1_oct6_x",    px[5], 80);
    chk("c1_oct6_y",    py[5], 57);
    chk("c1_s1_x",      px[8], 83);
    chk("c1_s1_y",      py[8], 61);
    chk("c1_s2_x",      px[16], 82);
    chk("c1_s2_y",      py[16], 62);
    chk("c1_done_hold", int'(done), 1);
    finish_draw();
    chk("c1_done_fall", int'(done), 0);
    chk("c1_idle_plot", int'(vga_plot), 0);

    // Octant-1 arc only
    run_draw(80, 60, 3, 8'h01, 2);
    chk("c2_done_edge", done_edge, 25);
    chk("c2_nplots",    n_plots, 3);
    if (n_plots == 3) begin
      chk("c2_q0_x", qx[0], 83); chk("c2_q0_y", qy[0], 60);
      chk("c2_q1_x", qx[1], 83); chk("c2_q1_y", qy[1], 61);
      chk("c2_q2_x", qx[2], 82); chk("c2_q2_y", qy[2], 62);
    end
    finish_draw();

    // Clipping at the origin corner
    run_draw(0, 0, 3, 8'hFF, 1);
    pat = 0;
    for (int i = 0; i < 8; i++) if (pl[i] == 1) pat |= (1 << i);
    chk("c3_step0_pattern", pat, 32'h87);
    chk("c3_nplots",        n_plots, 8);
    chk("c3_offscreen",     n_bad, 0);
    chk("c3_done_edge",     done_edge, 25);
    finish_draw();

    // Clipping at the far corner, r=2
    run_draw(159, 119, 2, 8'hFF, 7);
    chk("c4_done_edge", done_edge, 17);
    chk("c4_nplots",    n_plots, 6);
    chk("c4_offscreen", n_bad, 0);
    chk("c4_p0_x",      px[0], 161);
    chk("c4_p0_plot",   pl[0], 0);
    chk("c4_oct6_x",    px[5], 159);
    chk("c4_oct6_plot", pl[5], 1);
    finish_draw();

    // Radius 0
    run_draw(10, 10, 0, 8'hFF, 3);
    chk("c5_done_edge", done_edge, 9);
    chk("c5_nplots",    n_plots, 8);
    pat = 0;
    for (int i = 0; i < qx.size(); i++) if (qx[i] == 10 && qy[i] == 10) pat++;
    chk("c5_at_centre", pat, 8);
    finish_draw();

    // Reset mid-draw at E10, then redraw
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd3; octant_mask = 8'hFF; colour = 3'd6;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 9; e++) tick();
    chk("c6_pre_x",    int'(vga_x), 83);
    chk("c6_pre_plot", int'(vga_plot), 1);
    rst_n = 1'b0;
    tick();
    chk("c6_rst_done",   int'(done), 0);
    chk("c6_rst_plot",   int'(vga_plot), 0);
    chk("c6_rst_x",      int'(vga_x), 0);
    chk("c6_rst_y",      int'(vga_y), 0);
    chk("c6_rst_colour", int'(vga_colour), 0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    run_draw(80, 60, 3, 8'hFF, 6);
    chk("c6_re_x",         px[0], 83);
    chk("c6_re_y",         py[0], 60);
    chk("c6_re_done_edge", done_edge, 25);
    finish_draw();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
